reg_file_sb: RTL

Parametrised, scoreboarded register file for the next-generation datapath. It has two combinational read ports, one clocked write port, optional write-to-read bypass and an optional hardwired zero register. A per-register busy bit is set when a multi-cycle producer issues and cleared when its result is written back, so decode can stall on read-after-write hazards. It sits between decode (read/issue) and writeback (write/clear).

---
 rtl/reg_file_sb_pkg.sv | 11 +
 rtl/rf_scoreboard.sv | 61 ++++++
 rtl/reg_file_sb.sv | 91 +++++++++
 3 files changed

// File: rtl/reg_file_sb_pkg.sv
// reg_file_sb shared constants.
// Default geometry, zero-register index and counter width helper.
package reg_file_sb_pkg;
   localparam int DATA_W_DEF = 32;
   localparam int ADDR_W_DEF = 5;
   localparam int ZERO_IDX   = 0;

   function automatic int cnt_w(input int aw);
      return aw + 1;
   endfunction
endpackage

// File: rtl/rf_scoreboard.sv
// rf_scoreboard: per-register busy bits for the register file.
// Issue beats clear on the same register; tracks busy count and errors.
import reg_file_sb_pkg::*;

module rf_scoreboard #(
   parameter int ADDR_W   = ADDR_W_DEF,
   parameter int ZERO_REG = 1
) (
   input  logic                   clk,
   input  logic                   areset,
   input  logic                   iss_en,
   input  logic [ADDR_W-1:0]      iss_addr,
   input  logic                   clr_en,
   input  logic [ADDR_W-1:0]      clr_addr,
   output logic [(2**ADDR_W)-1:0] busy,
   output logic [ADDR_W:0]        busy_cnt,
   output logic                   sb_err
);
   localparam int DEPTH = 2**ADDR_W;
   localparam int CNT_W = cnt_w(ADDR_W);
   localparam logic [ADDR_W-1:0] ZA = ADDR_W'(ZERO_IDX);

   logic [DEPTH-1:0] busy_q, busy_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             err_q, err_d;
   logic             iss_ok, clr_ok, inc, dec;

   always_comb begin
      iss_ok = iss_en && !((ZERO_REG != 0) && (iss_addr == ZA));
      clr_ok = clr_en && !((ZERO_REG != 0) && (clr_addr == ZA));
      busy_d = busy_q;
      if (clr_ok) busy_d[clr_addr] = 1'b0;
      if (iss_ok) busy_d[iss_addr] = 1'b1;
      // a clear on the register being re-issued leaves it busy
      inc = iss_ok && !busy_q[iss_addr];
      dec = clr_ok && busy_q[clr_addr]
            && !(iss_ok && (iss_addr == clr_addr));
      cnt_d = cnt_q;
      if (inc && !dec) cnt_d = cnt_q + CNT_W'(1);
      else if (dec && !inc) cnt_d = cnt_q - CNT_W'(1);
      err_d = err_q
            | (iss_ok && busy_q[iss_addr])
            | (clr_ok && !busy_q[clr_addr]);
   end

   always_ff @(posedge clk or posedge areset) begin
      if (areset) begin
         busy_q <= '0;
         cnt_q  <= '0;
         err_q  <= 1'b0;
      end else begin
         busy_q <= busy_d;
         cnt_q  <= cnt_d;
         err_q  <= err_d;
      end
   end

   assign busy     = busy_q;
   assign busy_cnt = cnt_q;
   assign sb_err   = err_q;
endmodule

// File: rtl/reg_file_sb.sv
// reg_file_sb: 2R1W register file with scoreboard and write bypass.
// Storage is a bank of per-register flops enabled from wr_addr.
import reg_file_sb_pkg::*;

module reg_file_sb #(
   parameter int DATA_W   = DATA_W_DEF,
   parameter int ADDR_W   = ADDR_W_DEF,
   parameter int ZERO_REG = 1,
   parameter int BYPASS   = 1
) (
   input  logic              clk,
   input  logic              areset,
   input  logic [ADDR_W-1:0] rd_addr1,
   input  logic [ADDR_W-1:0] rd_addr2,
   output logic [DATA_W-1:0] rd_data1,
   output logic [DATA_W-1:0] rd_data2,
   output logic              rd_busy1,
   output logic              rd_busy2,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              wr_clr,
   input  logic              iss_en,
   input  logic [ADDR_W-1:0] iss_addr,
   output logic [ADDR_W:0]   busy_cnt,
   output logic              sb_err
);
   localparam int DEPTH = 2**ADDR_W;
   localparam logic [ADDR_W-1:0] ZA = ADDR_W'(ZERO_IDX);

   logic [DATA_W-1:0] rf [DEPTH];
   logic [DEPTH-1:0]  busy;
   logic              z1, z2, hit1, hit2;

   for (genvar i = 0; i < DEPTH; i++) begin : g_reg
      if ((ZERO_REG != 0) && (i == ZERO_IDX)) begin : g_zero
         assign rf[i] = '0;
      end else begin : g_live
         logic              we;
         logic [DATA_W-1:0] data_q, data_d;

         assign we = wr_en && (wr_addr == ADDR_W'(i));

         always_comb begin
            data_d = data_q;
            if (we) data_d = wr_data;
         end

         always_ff @(posedge clk or posedge areset) begin
            if (areset) data_q <= '0;
            else        data_q <= data_d;
         end

         assign rf[i] = data_q;
      end
   end

   rf_scoreboard #(
      .ADDR_W   (ADDR_W),
      .ZERO_REG (ZERO_REG)
   ) u_sb (
      .clk      (clk),
      .areset   (areset),
      .iss_en   (iss_en),
      .iss_addr (iss_addr),
      .clr_en   (wr_en && wr_clr),
      .clr_addr (wr_addr),
      .busy     (busy),
      .busy_cnt (busy_cnt),
      .sb_err   (sb_err)
   );

   always_comb begin
      z1   = (ZERO_REG != 0) && (rd_addr1 == ZA);
      z2   = (ZERO_REG != 0) && (rd_addr2 == ZA);
      hit1 = (BYPASS != 0) && wr_en && (wr_addr == rd_addr1) && !z1;
      hit2 = (BYPASS != 0) && wr_en && (wr_addr == rd_addr2) && !z2;
      rd_data1 = hit1 ? wr_data : rf[rd_addr1];
      rd_data2 = hit2 ? wr_data : rf[rd_addr2];
      rd_busy1 = busy[rd_addr1] && !(hit1 && wr_clr);
      rd_busy2 = busy[rd_addr2] && !(hit2 && wr_clr);
      if (z1) begin
         rd_data1 = '0;
         rd_busy1 = 1'b0;
      end
      if (z2) begin
         rd_data2 = '0;
         rd_busy2 = 1'b0;
      end
   end
endmodule
